usb_rx_wire_arbiter: RTL and testbench

USB_RX_WIRE_ARBITER -- requirements
Module: usb_rx_wire_arbiter

---
 rtl/usb_rx_arb_pkg.sv | 9 +
 rtl/usb_rx_sample_fifo.sv | 51 +++++
 rtl/usb_rx_wire_arbiter.sv | 90 +++++++++
 tb/tb_usb_rx_wire_arbiter.sv | 132 +++++++++++++
 4 files changed

// File: rtl/usb_rx_arb_pkg.sv
// usb_rx_arb_pkg: shared FSM state encoding and default buffer depth for the USB RX wire arbiter
package usb_rx_arb_pkg;
    localparam int DEFAULT_FIFO_DEPTH = 4;
    typedef logic [1:0] arb_state_t;
    localparam arb_state_t START   = 2'd0;
    localparam arb_state_t IDLE    = 2'd1;
    localparam arb_state_t PRC_GNT = 2'd2;
    localparam arb_state_t SIE_GNT = 2'd3;
endpackage

// File: rtl/usb_rx_sample_fifo.sv
// usb_rx_sample_fifo: 2-bit sample buffer with push/pop/flush
//   clk, rst      : clock, synchronous active-high reset
//   push_i/data_i : write a sample (accepted when not full, or when full and popping)
//   pop_i         : remove the head sample (ignored when empty)
//   flush_i       : empty the buffer; wins over a coincident push/pop
//   data_o        : head sample, 2'b00 when empty
//   full_o/empty_o/count_o : occupancy status
module usb_rx_sample_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [1:0]               data_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic [1:0]               data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    logic [1:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push, do_pop;
    assign empty_o = count_q == '0;
    assign full_o  = count_q == FULL_CNT;
    assign count_o = count_q;
    assign data_o  = empty_o ? 2'b00 : mem_q[rd_ptr_q];
    assign do_pop  = pop_i & ~empty_o & ~flush_i;
    // A full buffer still takes a push when the head leaves on the same edge.
    assign do_push = push_i & ~flush_i & (~full_o | do_pop);
    // Depth is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push && !rst) mem_q[wr_ptr_q] <= data_i;
    end
endmodule

// File: rtl/usb_rx_wire_arbiter.sv
// usb_rx_wire_arbiter: grants the USB RX wire to the bit-processor or the SIE and buffers samples for the owner
//   clk, rst                    : clock, synchronous active-high reset
//   RxBits, RxWireWEn           : sampled line state and its strobe
//   prcRxBitReq/Gnt/Data/WEn/Rdy: bit-processor request, grant and sample handshake (fixed priority)
//   SIERxReq/Gnt/Data/WEn/Rdy   : SIE request, grant and sample handshake
//   RxOverflow                  : sticky, a sample was dropped on a full buffer while granted
module usb_rx_wire_arbiter
    import usb_rx_arb_pkg::*;
#(
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] RxBits,
    input  logic       RxWireWEn,
    input  logic       prcRxBitReq,
    output logic       prcRxBitGnt,
    output logic [1:0] prcRxBitData,
    output logic       prcRxBitWEn,
    input  logic       prcRxBitRdy,
    input  logic       SIERxReq,
    output logic       SIERxGnt,
    output logic [1:0] SIERxData,
    output logic       SIERxWEn,
    input  logic       SIERxRdy,
    output logic       RxOverflow
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    arb_state_t    state_q, state_d;
    logic          prc_gnt_q, prc_gnt_d;
    logic          sie_gnt_q, sie_gnt_d;
    logic          ovf_q, ovf_d;
    logic          flush, push, pop, enter_idle;
    logic [1:0]    fifo_head;
    logic          fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    always_comb begin
        state_d = state_q == START   ? IDLE :
                  state_q == IDLE    ? (prcRxBitReq ? PRC_GNT : SIERxReq ? SIE_GNT : IDLE) :
                  state_q == PRC_GNT ? (prcRxBitReq ? PRC_GNT : IDLE) :
                                       (SIERxReq ? SIE_GNT : IDLE);
        prc_gnt_d  = state_d == PRC_GNT;
        sie_gnt_d  = state_d == SIE_GNT;
        // Losing the request drops ownership and any samples buffered for that owner.
        flush      = (state_q == PRC_GNT && !prcRxBitReq) || (state_q == SIE_GNT && !SIERxReq);
        push       = RxWireWEn & (prc_gnt_q | sie_gnt_q);
        pop        = (prcRxBitWEn & prcRxBitRdy) | (SIERxWEn & SIERxRdy);
        enter_idle = state_d == IDLE && state_q != IDLE;
        ovf_d      = enter_idle ? 1'b0 : ovf_q | (push & fifo_full & ~pop & ~flush);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= START;
            prc_gnt_q <= 1'b0;
            sie_gnt_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            prc_gnt_q <= prc_gnt_d;
            sie_gnt_q <= sie_gnt_d;
            ovf_q     <= ovf_d;
        end
    end
    usb_rx_sample_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .data_i  (RxBits),
        .pop_i   (pop),
        .flush_i (flush),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );
    // Sanity checks ignored by synthesis: exclusive grants, bounded occupancy.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(prc_gnt_q && sie_gnt_q));
            assert (fifo_count <= CW'(FIFO_DEPTH));
        end
    end
    assign prcRxBitGnt  = prc_gnt_q;
    assign SIERxGnt     = sie_gnt_q;
    assign prcRxBitWEn  = prc_gnt_q & ~fifo_empty;
    assign SIERxWEn     = sie_gnt_q & ~fifo_empty;
    assign prcRxBitData = prc_gnt_q ? fifo_head : 2'b00;
    assign SIERxData    = sie_gnt_q ? fifo_head : 2'b00;
    assign RxOverflow   = ovf_q;
endmodule

// File: tb/tb_usb_rx_wire_arbiter.sv
// tb_usb_rx_wire_arbiter: directed and random checks of the wire arbiter against an ownership/queue model
module tb_usb_rx_wire_arbiter;
    localparam int DEPTH = 4;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] RxBits = 2'b00;
    logic       RxWireWEn = 1'b0;
    logic       prcRxBitReq = 1'b0, prcRxBitRdy = 1'b0;
    logic       SIERxReq = 1'b0, SIERxRdy = 1'b0;
    logic       prcRxBitGnt, prcRxBitWEn, SIERxGnt, SIERxWEn, RxOverflow;
    logic [1:0] prcRxBitData, SIERxData;
    int tests = 0;
    int fails = 0;
    // Model: owner -1 = coming out of reset, 0 = nobody, 1 = bit-processor, 2 = SIE.
    int         owner = -1;
    logic [1:0] q[$];
    bit         ovf = 1'b0;

    usb_rx_wire_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .RxBits(RxBits), .RxWireWEn(RxWireWEn),
        .prcRxBitReq(prcRxBitReq), .prcRxBitGnt(prcRxBitGnt), .prcRxBitData(prcRxBitData),
        .prcRxBitWEn(prcRxBitWEn), .prcRxBitRdy(prcRxBitRdy),
        .SIERxReq(SIERxReq), .SIERxGnt(SIERxGnt), .SIERxData(SIERxData),
        .SIERxWEn(SIERxWEn), .SIERxRdy(SIERxRdy), .RxOverflow(RxOverflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic check_all();
        check("prc_gnt", prcRxBitGnt, owner == 1);
        check("sie_gnt", SIERxGnt, owner == 2);
        check("prc_wen", prcRxBitWEn, owner == 1 && q.size() > 0);
        check("sie_wen", SIERxWEn, owner == 2 && q.size() > 0);
        if (owner == 1 && q.size() > 0) check("prc_data", prcRxBitData, q[0]);
        else if (owner != 1) check("prc_data_idle", prcRxBitData, 0);
        if (owner == 2 && q.size() > 0) check("sie_data", SIERxData, q[0]);
        else if (owner != 2) check("sie_data_idle", SIERxData, 0);
        check("overflow", RxOverflow, ovf);
    endtask

    task automatic model_step();
        bit req, rdy, do_pop;
        if (rst) begin
            owner = -1; q.delete(); ovf = 1'b0;
        end else if (owner == -1) begin
            owner = 0; ovf = 1'b0;
        end else if (owner == 0) begin
            owner = prcRxBitReq ? 1 : SIERxReq ? 2 : 0;
        end else begin
            req = owner == 1 ? prcRxBitReq : SIERxReq;
            rdy = owner == 1 ? prcRxBitRdy : SIERxRdy;
            if (!req) begin
                owner = 0; q.delete(); ovf = 1'b0;
            end else begin
                do_pop = q.size() > 0 && rdy;
                if (RxWireWEn && q.size() == DEPTH && !do_pop) ovf = 1'b1;
                else begin
                    if (do_pop) void'(q.pop_front());
                    if (RxWireWEn) q.push_back(RxBits);
                end
            end
        end
    endtask

    task automatic tick(input bit r, input bit pq, input bit sq, input bit pr, input bit sr,
                        input bit we, input logic [1:0] b);
        @(negedge clk);
        check_all();
        rst = r; prcRxBitReq = pq; SIERxReq = sq; prcRxBitRdy = pr; SIERxRdy = sr;
        RxWireWEn = we; RxBits = b;
        model_step();
    endtask

    initial begin
        model_step();
        tick(1, 0, 0, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0, 1, 3);
        // Release reset, request from the bit-processor; late samples are discarded.
        tick(0, 0, 0, 0, 0, 1, 2);
        tick(0, 1, 0, 1, 0, 1, 1);
        tick(0, 1, 0, 1, 0, 0, 0);
        // Streaming with one-cycle latency.
        tick(0, 1, 1, 1, 1, 1, 2'b01);
        tick(0, 1, 1, 1, 1, 1, 2'b10);
        tick(0, 1, 1, 1, 1, 1, 2'b11);
        tick(0, 1, 1, 1, 1, 0, 0);
        tick(0, 1, 1, 1, 1, 0, 0);
        // Drop bit-processor request; SIE takes over via IDLE.
        tick(0, 0, 1, 0, 0, 0, 0);
        tick(0, 0, 1, 0, 0, 0, 0);
        tick(0, 0, 1, 0, 0, 0, 0);
        // SIE stalled: five pushes on depth four.
        for (int i = 0; i < 5; i++) tick(0, 0, 1, 0, 0, 1, 2'(i));
        tick(0, 0, 1, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 0, 0);
        // Full buffer with simultaneous push and pop across the pointer wrap.
        tick(0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) tick(0, 0, 1, 0, 0, 1, 2'(3 - i));
        for (int i = 0; i < 7; i++) tick(0, 0, 1, 0, 1, 1, 2'(i));
        tick(0, 0, 1, 0, 1, 0, 0);
        tick(0, 0, 0, 0, 0, 0, 0);
        // Reset with three samples held by the bit-processor.
        tick(0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) tick(0, 1, 0, 0, 0, 1, 2'(i + 1));
        tick(1, 1, 0, 0, 0, 0, 0);
        tick(0, 1, 0, 1, 0, 0, 0);
        tick(0, 1, 0, 1, 0, 0, 0);
        tick(0, 1, 0, 1, 0, 0, 0);
        tick(0, 1, 0, 1, 0, 0, 0);
        // Random traffic with sticky requests and rare resets.
        for (int i = 0; i < 3000; i++) begin
            bit pq, sq;
            pq = ($urandom_range(0, 9) < 8) ? prcRxBitReq : ~prcRxBitReq;
            sq = ($urandom_range(0, 9) < 8) ? SIERxReq : ~SIERxReq;
            tick($urandom_range(0, 99) == 0, pq, sq, 1'($urandom), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 9) < 6), 2'($urandom));
        end
        @(negedge clk);
        check_all();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
